// File: rtl/booth_pp_reducer.sv
// ----------------------------------------------------------------------------
// booth_pp_reducer
//
// Sequential reducer for the radix-4 Booth partial-product bus of the 8x8
// multiplier. It takes one set of five 9-bit two's-complement rows plus their
// +1 negate corrections, and accumulates them into a 16-bit product over a few
// cycles. It then presents the product on an output handshake.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where valid
// and ready are both high. A source holds valid and its data stable until that
// edge. Ready never depends combinationally on valid.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   pp_in/neg_in carry a row set
//   in_ready   block is IDLE and will accept a row set
//   pp_in      packed rows {pp4,pp3,pp2,pp1,pp0}, row i = pp_in[9i+8:9i]
//   neg_in     bit i is the +1 correction for row i
//   out_valid  product is valid (DONE state)
//   out_ready  downstream accepts the product
//   product    accumulated result modulo 2^16; holds its last value between
//              results
//   busy       high while accumulating or holding a result
//   dbg_state  current FSM state (0 IDLE, 1 ACC, 2 DONE) for observation
//
// Build option:
//   BOOTH_REDUCER_DUAL_ROW_EN  when defined, two rows are added per cycle.
//                              The groups are {0,1}, {2,3}, then {4}, so the
//                              latency is 3 edges. When undefined, one row is
//                              added per cycle and the latency is 5 edges.
//                              The product is identical in both builds.
// ----------------------------------------------------------------------------
module booth_pp_reducer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [44:0] pp_in,
    input  logic [4:0]  neg_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

`ifdef BOOTH_REDUCER_DUAL_ROW_EN
    localparam logic [2:0] K_STEP = 3'd2;
`else
    localparam logic [2:0] K_STEP = 3'd1;
`endif

    state_e      state_q;
    logic [44:0] pp_q;
    logic [4:0]  neg_q;
    logic [15:0] acc_q;
    logic [15:0] acc_d;
    logic [2:0]  k_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;
    logic [15:0] product_q;

    // Weighted value of every captured row: (sext16(row_i) + neg_i) << 2i.
    logic [15:0] term [5];
    logic [15:0] step_sum;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            term[i] = ({{7{pp_q[9*i+8]}}, pp_q[9*i +: 9]} + {15'd0, neg_q[i]}) << (2*i);
        end
    end

    // Contribution for the current cycle, selected by the row counter.
    always_comb begin
        step_sum = 16'd0;
        case (k_q)
`ifdef BOOTH_REDUCER_DUAL_ROW_EN
            3'd0:    step_sum = term[0] + term[1];
            3'd2:    step_sum = term[2] + term[3];
            3'd4:    step_sum = term[4];
`else
            3'd0:    step_sum = term[0];
            3'd1:    step_sum = term[1];
            3'd2:    step_sum = term[2];
            3'd3:    step_sum = term[3];
            3'd4:    step_sum = term[4];
`endif
            default: step_sum = 16'd0;
        endcase
    end

    // With the two-row adder, this is a 3-input 16-bit add.
    assign acc_d = acc_q + step_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pp_q        <= 45'd0;
            neg_q       <= 5'd0;
            acc_q       <= 16'd0;
            k_q         <= 3'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            product_q   <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        pp_q       <= pp_in;
                        neg_q      <= neg_in;
                        acc_q      <= 16'd0;
                        k_q        <= 3'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + K_STEP;
                    // Row 4 is always the last add in both builds.
                    if (k_q == 3'd4) begin
                        product_q   <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_pp_reducer.sv
module tb_booth_pp_reducer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [44:0] pp_in;
  logic [4:0]  neg_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  logic [1:0]  dbg_state;

`ifdef BOOTH_REDUCER_DUAL_ROW_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 5;
`endif

  int tests_run = 0;
  int fail_cnt  = 0;
  logic [15:0] exp_q[$];

  booth_pp_reducer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp_in     (pp_in),
    .neg_in    (neg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Signed integer sum of (row_i + neg_i) * 4^i, reduced modulo 2^16.
  function automatic logic [15:0] model(input logic [44:0] pp, input logic [4:0] neg);
    int total;
    total = 0;
    for (int i = 0; i < 5; i++) begin
      logic [44:0] sh;
      int r;
      sh = pp >> (9 * i);
      r = int'(sh[8:0]);
      if (r > 255) r = r - 512;
      total = total + (r + int'(neg[i])) * (1 << (2 * i));
    end
    return total[15:0];
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Sends one row set, checks latency and product, and applies rdy_delay
  // cycles of output backpressure before the output handshake.
  task automatic do_txn(input logic [44:0] pp, input logic [4:0] neg,
                        input int rdy_delay, input string tag);
    int cyc;
    logic [15:0] exp;
    exp_q.push_back(model(pp, neg));
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_in_ready_timeout"}, 32'(cyc < 50), 32'd1);
    pp_in    = pp;
    neg_in   = neg;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    pp_in    = 45'({$urandom(), $urandom()});
    neg_in   = 5'($urandom_range(0, 31));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    exp = exp_q.pop_front();
    check({tag, "_product"}, 32'(product), 32'(exp));
    for (int d = 0; d < rdy_delay; d++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_product"}, 32'(product), 32'(exp));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    check({tag, "_product_keep"}, 32'(product), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [44:0] pp;
    logic [44:0] all_ff;
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pp_in     = 45'd0;
    neg_in    = 5'd0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases
    do_txn(45'h0000000603, 5'b00000, 0, "basic_3x5");
    check("basic_value", 32'(product), 32'h000F);
    do_txn(45'h00000001FC, 5'b00001, 0, "neg_row0");
    check("neg_row0_value", 32'(product), 32'hFFFD);
    pp = 45'h1FF << 36;
    do_txn(pp, 5'b10000, 1, "neg_row4");
    check("neg_row4_value", 32'(product), 32'h0000);
    pp = 45'h0FF << 36;
    do_txn(pp, 5'b00000, 0, "top_row");
    check("top_row_value", 32'(product), 32'hFF00);
    all_ff = {5{9'h0FF}};
    do_txn(all_ff, 5'b11111, 2, "all_ff");
    do_txn({5{9'h100}}, 5'b11111, 0, "all_min");

    // Back-to-back initiation interval with out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    pp_in     = 45'h0000000603;
    neg_in    = 5'd0;
    @(negedge clk);
    pp_in = 45'h0000000A05;
    cyc = 1;
    while (!in_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ii_cycles", 32'(cyc), 32'(LAT + 2));
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ii_second_product", 32'(product), 32'(model(45'h0000000A05, 5'd0)));
    @(negedge clk);
    out_ready = 1'b0;

    // Backpressure: new in_valid must be ignored while DONE is held
    exp_q.push_back(model(45'h0000001005, 5'b00010));
    pp_in    = 45'h0000001005;
    neg_in   = 5'b00010;
    in_valid = 1'b1;
    @(negedge clk);
    pp_in = 45'h1FFFFFFFFFF;
    neg_in = 5'b11111;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", 32'(cyc), 32'(LAT));
    for (int d = 0; d < 10; d++) begin
      @(negedge clk);
      check("bp_product_stable", 32'(product), 32'(exp_q[0]));
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_valid_held", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_product", 32'(product), 32'(exp_q.pop_front()));

    // Reset in the middle of accumulation
    pp_in    = 45'h0000000603;
    neg_in   = 5'd0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_product", 32'(product), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    do_txn(45'h0000000603, 5'b00000, 0, "post_rst_3x5");
    check("post_rst_value", 32'(product), 32'h000F);

    // Randomised row sets
    for (int n = 0; n < 16; n++) begin
      do_txn(45'({$urandom(), $urandom()}), 5'($urandom_range(0, 31)),
             $urandom_range(0, 3), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    fail_cnt++;
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/booth_pp_reducer.md
# booth_pp_reducer

Sequential consumer for the packed radix-4 Booth partial-product bus of the 8x8 multiplier datapath. Accepts one set of five 9-bit partial-product rows plus their negate (+1 correction) bits over a valid/ready handshake, sums them row by row into a 16-bit product, and returns the product over a second valid/ready handshake. It sits directly downstream of the Booth selector, in place of a combinational compressor tree, and trades latency for area.

## Interface
- No parameters; widths fixed: 5 rows x 9 bits, 16-bit product.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  pp_in/neg_in hold a valid row set.
- in_ready  out  1  block can accept a row set.
- pp_in  in  45  packed rows {pp4,pp3,pp2,pp1,pp0}; row i = pp_in[9i+8:9i].
- neg_in  in  5  bit i = negate-correction for row i (added as +1 at row LSB).
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- product  out  16  result, modulo 2^16.
- busy  out  1  high in ACC and DONE.

## Operation
- States: IDLE, ACC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: register pp_in and neg_in, clear acc to 0, row counter k=0, go to ACC. Input ports are not sampled again until the next IDLE.
- ACC: in_ready=0. Each cycle acc <= acc + ((sext16(row_k) + neg_k) << 2k); k <= k+1. After the row-4 add, go to DONE.
- Row value: row_k is 9-bit two's complement, sign-extended from bit 8 to 16 bits. neg_k is zero-extended. All adds wrap modulo 2^16; no overflow flag.
- DONE: out_valid=1, product=acc, held stable until out_ready. On out_valid&out_ready go to IDLE. in_ready stays 0 in DONE, so there is no overlap of a new accept with a pending output.
- product keeps its last value in IDLE/ACC. Consumers qualify it with out_valid only.
- in_valid while busy is ignored; the source must hold it (standard valid/ready).
- Reset (asynchronous, any state, including mid-ACC): state=IDLE, acc=0, k=0, captured regs=0, in_ready=1 (once rst_n is high), out_valid=0, busy=0, product=0. A partial accumulation is discarded.

## Timing
- Accept on edge E0. Rows are added on edges E1..E5. out_valid is high after E5 (5-cycle latency, single-row mode).
- Earliest next accept: the edge after the out_valid&out_ready edge. Minimum initiation interval is 7 cycles when out_ready is held high.
- out_ready low: DONE holds indefinitely, with product and out_valid stable.
- With BOOTH_REDUCER_DUAL_ROW_EN: latency 3 edges (rows {0,1}, {2,3}, {4}); initiation interval 5 cycles.

## Configuration
- BOOTH_REDUCER_DUAL_ROW_EN defined: ACC adds two rows per cycle (k steps by 2) using a 3-input 16-bit add. The final cycle adds row 4 alone. Latency is 3.
- Undefined: one row per cycle, latency 5. The result is bit-identical in both modes; only out_valid timing differs.

## Test plan
- Basic: pp_in=45'h0000000603, neg_in=0 (3x5) -> out_valid 5 cycles after accept, product=16'h000F.
- Negation: pp_in=45'h00000001FC, neg_in=5'b00001 -> product=16'hFFFD. Also pp_in=45'h1FF<<36 (row 4 = -1), neg_in=5'b10000 -> product=16'h0000.
- Top row/wrap: row 4 = 9'h0FF, others 0, neg_in=0 -> product=16'hFF00. All rows 9'h0FF, neg_in=5'b11111 -> product equals the modulo-2^16 sum of a golden model.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> product stable, in_ready=0, and a new in_valid is not accepted. Raise out_ready -> one handshake, then in_ready=1 the next cycle.
- Reset mid-op: drop rst_n at cycle 2 of ACC -> outputs go to their reset values immediately. After release, a fresh 3x5 set yields 16'h000F with no residue.
- Dual-row build: repeat the first three scenarios with BOOTH_REDUCER_DUAL_ROW_EN -> identical products, out_valid 3 cycles after accept.
